mole_field_ctrl: RTL and testbench

MOLE_FIELD_CTRL -- requirements
Module: mole_field_ctrl

---
 rtl/mole_field_ctrl.sv | 159 +++++++++++++++
 tb/tb_mole_field_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_field_ctrl.sv
// Whack-a-mole playfield controller: LFSR-chosen spawns, per-mole lifetime counters,
// and registered hit / miss / timeout reporting, all frozen while enable is low.
module mole_field_ctrl #(
  parameter int          NUM_MOLES  = 5,
  parameter int          MAX_ACTIVE = 2,
  parameter int          TICKS_EASY = 10,
  parameter int          TICKS_MED  = 7,
  parameter int          TICKS_HARD = 4,
  parameter int          SPAWN_GAP  = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk_game,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           level,
  input  logic [NUM_MOLES-1:0] btn_hit_pulse,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic                 hit_pulse,
  output logic [4:0]           hit_count,
  output logic                 miss_pulse,
  output logic                 timeout_pulse,
  output logic [4:0]           active_count
);

  localparam logic [7:0] NUM_MOLES_W  = 8'(NUM_MOLES);
  localparam logic [4:0] MAX_ACTIVE_W = 5'(MAX_ACTIVE);
  localparam logic [7:0] SPAWN_GAP_W  = 8'(SPAWN_GAP);

  logic [NUM_MOLES-1:0] mole_led_r;
  logic [NUM_MOLES-1:0] led_nxt_s;
  logic [7:0]           cnt_r     [NUM_MOLES];
  logic [7:0]           cnt_nxt_s [NUM_MOLES];
  logic [15:0]          lfsr_r;
  logic [15:0]          lfsr_nxt_s;
  logic [7:0]           gap_r;
  logic [7:0]           gap_nxt_s;
  logic                 hit_pulse_r;
  logic                 miss_pulse_r;
  logic                 timeout_pulse_r;
  logic [4:0]           hit_count_r;
  logic [4:0]           active_count_r;
  logic [4:0]           hits_s;
  logic [4:0]           active_nxt_s;
  logic                 miss_s;
  logic                 timeout_s;
  logic                 spawn_s;
  logic [7:0]           start_s;
  int                   best_dist_s;
  int                   target_s;
  int                   dist_s;

  function automatic logic [7:0] level_ticks(input logic [1:0] lvl);
    logic [7:0] t;
    case (lvl)
      2'd0:    t = 8'(TICKS_EASY);
      2'd1:    t = 8'(TICKS_MED);
      default: t = 8'(TICKS_HARD);
    endcase
    return t;
  endfunction

  // Spawn decision and target: nearest mole unlit before this edge, scanning up from the LFSR start.
  always_comb begin
    start_s     = lfsr_r[7:0] % NUM_MOLES_W;
    spawn_s     = enable && (gap_r == 8'd0) && (active_count_r < MAX_ACTIVE_W);
    best_dist_s = NUM_MOLES;
    target_s    = 0;
    dist_s      = 0;
    for (int j = 0; j < NUM_MOLES; j++) begin
      dist_s      = (j >= int'(start_s)) ? (j - int'(start_s)) : (j + NUM_MOLES - int'(start_s));
      target_s    = (!mole_led_r[j] && (dist_s < best_dist_s)) ? j : target_s;
      best_dist_s = (!mole_led_r[j] && (dist_s < best_dist_s)) ? dist_s : best_dist_s;
    end
  end

  // Next-state of moles, counters, LFSR and gap counter, plus the event flags for this edge.
  always_comb begin
    led_nxt_s    = mole_led_r;
    cnt_nxt_s    = cnt_r;
    lfsr_nxt_s   = lfsr_r;
    gap_nxt_s    = gap_r;
    hits_s       = 5'd0;
    miss_s       = 1'b0;
    timeout_s    = 1'b0;
    active_nxt_s = 5'd0;
    if (enable) begin
      lfsr_nxt_s = {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
      if (spawn_s) begin
        gap_nxt_s = SPAWN_GAP_W;
      end else if (gap_r != 8'd0) begin
        gap_nxt_s = gap_r - 8'd1;
      end else begin
        gap_nxt_s = 8'd0;
      end
      for (int j = 0; j < NUM_MOLES; j++) begin
        if (mole_led_r[j]) begin
          // A press wins over a same-cycle expiry.
          if (btn_hit_pulse[j]) begin
            led_nxt_s[j] = 1'b0;
            hits_s       = hits_s + 5'd1;
          end else if (cnt_r[j] == 8'd1) begin
            led_nxt_s[j] = 1'b0;
            timeout_s    = 1'b1;
          end else begin
            cnt_nxt_s[j] = cnt_r[j] - 8'd1;
          end
        end else begin
          miss_s = miss_s | btn_hit_pulse[j];
          if (spawn_s && (target_s == j)) begin
            led_nxt_s[j] = 1'b1;
            cnt_nxt_s[j] = level_ticks(level);
          end else begin
            led_nxt_s[j] = 1'b0;
          end
        end
      end
    end else begin
      lfsr_nxt_s = lfsr_r;
    end
    for (int j = 0; j < NUM_MOLES; j++) begin
      active_nxt_s = active_nxt_s + {4'd0, led_nxt_s[j]};
    end
  end

  // State and output registers.
  always_ff @(posedge clk_game or posedge rst) begin
    if (rst) begin
      mole_led_r      <= {NUM_MOLES{1'b0}};
      for (int j = 0; j < NUM_MOLES; j++) begin
        cnt_r[j] <= 8'd0;
      end
      lfsr_r          <= LFSR_SEED;
      gap_r           <= 8'd0;
      hit_pulse_r     <= 1'b0;
      hit_count_r     <= 5'd0;
      miss_pulse_r    <= 1'b0;
      timeout_pulse_r <= 1'b0;
      active_count_r  <= 5'd0;
    end else begin
      mole_led_r      <= led_nxt_s;
      cnt_r           <= cnt_nxt_s;
      lfsr_r          <= lfsr_nxt_s;
      gap_r           <= gap_nxt_s;
      hit_pulse_r     <= (hits_s != 5'd0);
      hit_count_r     <= hits_s;
      miss_pulse_r    <= miss_s;
      timeout_pulse_r <= timeout_s;
      active_count_r  <= active_nxt_s;
    end
  end

  assign mole_led      = mole_led_r;
  assign hit_pulse     = hit_pulse_r;
  assign hit_count     = hit_count_r;
  assign miss_pulse    = miss_pulse_r;
  assign timeout_pulse = timeout_pulse_r;
  assign active_count  = active_count_r;

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Randomized bench for mole_field_ctrl with a behavioural game model plus directed scenarios.
module tb_mole_field_ctrl;

  localparam int          N    = 5;
  localparam int          MAXA = 2;
  localparam int          TE   = 10;
  localparam int          TM   = 7;
  localparam int          TH   = 4;
  localparam int          GAP  = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk_game = 1'b0;
  logic         rst;
  logic         enable;
  logic [1:0]   level;
  logic [N-1:0] btn_hit_pulse;
  logic [N-1:0] mole_led;
  logic         hit_pulse;
  logic [4:0]   hit_count;
  logic         miss_pulse;
  logic         timeout_pulse;
  logic [4:0]   active_count;

  mole_field_ctrl #(
    .NUM_MOLES(N), .MAX_ACTIVE(MAXA), .TICKS_EASY(TE), .TICKS_MED(TM),
    .TICKS_HARD(TH), .SPAWN_GAP(GAP), .LFSR_SEED(SEED)
  ) dut (
    .clk_game(clk_game), .rst(rst), .enable(enable), .level(level),
    .btn_hit_pulse(btn_hit_pulse), .mole_led(mole_led), .hit_pulse(hit_pulse),
    .hit_count(hit_count), .miss_pulse(miss_pulse), .timeout_pulse(timeout_pulse),
    .active_count(active_count)
  );

  always #5 clk_game = ~clk_game;

  int n_checks = 0;
  int n_errors = 0;

  // game model state
  bit           m_lit [N];
  int           m_life[N];
  int           m_lfsr;
  int           m_gap;
  logic [N-1:0] exp_led;
  logic         exp_hit, exp_miss, exp_tmo;
  int           exp_hcnt, exp_act;

  logic [N-1:0] prev_led;
  int           en_edges;
  int           last_spawn;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ticks_for(input logic [1:0] lv);
    if (lv == 2'd0) return TE;
    if (lv == 2'd1) return TM;
    return TH;
  endfunction

  function automatic int model_active();
    int c = 0;
    for (int j = 0; j < N; j++) c += int'(m_lit[j]);
    return c;
  endfunction

  function automatic void model_publish();
    for (int j = 0; j < N; j++) exp_led[j] = m_lit[j];
    exp_act = model_active();
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      m_lit[j]  = 1'b0;
      m_life[j] = 0;
    end
    m_lfsr = int'(SEED);
    m_gap  = 0;
    exp_hit = 1'b0; exp_miss = 1'b0; exp_tmo = 1'b0; exp_hcnt = 0;
    model_publish();
  endfunction

  function automatic void model_step(input logic en, input logic [1:0] lv, input logic [N-1:0] btn);
    int tgt, start, idx, fb;
    exp_hit = 1'b0; exp_miss = 1'b0; exp_tmo = 1'b0; exp_hcnt = 0;
    if (en) begin
      tgt = -1;
      if (m_gap == 0 && model_active() < MAXA) begin
        start = (m_lfsr & 255) % N;
        for (int k = 0; k < N; k++) begin
          idx = (start + k) % N;
          if (tgt < 0 && !m_lit[idx]) tgt = idx;
        end
      end
      for (int j = 0; j < N; j++) begin
        if (m_lit[j]) begin
          if (btn[j]) begin
            m_lit[j] = 1'b0;
            exp_hcnt++;
          end else if (m_life[j] == 1) begin
            m_lit[j] = 1'b0;
            exp_tmo  = 1'b1;
          end else begin
            m_life[j]--;
          end
        end else if (btn[j]) begin
          exp_miss = 1'b1;
        end
      end
      if (tgt >= 0) begin
        m_lit[tgt]  = 1'b1;
        m_life[tgt] = ticks_for(lv);
        m_gap       = GAP;
      end else if (m_gap > 0) begin
        m_gap--;
      end
      exp_hit = (exp_hcnt > 0);
      fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | (fb << 15);
    end
    model_publish();
  endfunction

  task automatic step(input logic en, input logic [1:0] lv, input logic [N-1:0] btn);
    logic [N-1:0] new_bits;
    enable = en; level = lv; btn_hit_pulse = btn;
    @(posedge clk_game);
    model_step(en, lv, btn);
    @(negedge clk_game);
    check_value("mole_led",      32'(mole_led),      32'(exp_led));
    check_value("hit_pulse",     32'(hit_pulse),     32'(exp_hit));
    check_value("hit_count",     32'(hit_count),     32'(exp_hcnt));
    check_value("miss_pulse",    32'(miss_pulse),    32'(exp_miss));
    check_value("timeout_pulse", 32'(timeout_pulse), 32'(exp_tmo));
    check_value("active_count",  32'(active_count),  32'(exp_act));
    check_value("max_active",    32'(active_count <= 5'(MAXA)), 32'd1);
    if (en) en_edges++;
    new_bits = mole_led & ~prev_led;
    if (new_bits != {N{1'b0}}) begin
      check_value("one_spawn", 32'($countones(new_bits)), 32'd1);
      if (last_spawn >= 0) check_value("spawn_gap", 32'((en_edges - last_spawn) >= GAP), 32'd1);
      last_spawn = en_edges;
    end
    prev_led = mole_led;
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_led"},  32'(mole_led),      32'd0);
    check_value({tag, "_hit"},  32'(hit_pulse),     32'd0);
    check_value({tag, "_hcnt"}, 32'(hit_count),     32'd0);
    check_value({tag, "_miss"}, 32'(miss_pulse),    32'd0);
    check_value({tag, "_tmo"},  32'(timeout_pulse), 32'd0);
    check_value({tag, "_act"},  32'(active_count),  32'd0);
  endtask

  function automatic void clear_history();
    prev_led   = {N{1'b0}};
    last_spawn = -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           first_idx, k;
    bit           found;
    logic [31:0]  rnd;
    logic [N-1:0] btn, snap;

    rst = 1'b1; enable = 1'b0; level = 2'd0; btn_hit_pulse = {N{1'b0}};
    model_reset(); clear_history(); en_edges = 0;
    #1;
    check_all_zero("reset");
    @(negedge clk_game); @(negedge clk_game);
    rst = 1'b0;

    // First spawn on the first enabled edge, then a 10-cycle lifetime at easy level
    step(1'b1, 2'd0, {N{1'b0}});
    check_value("first_spawn_count", 32'(active_count), 32'd1);
    first_idx = 0;
    for (int j = 0; j < N; j++) if (m_lit[j]) first_idx = j;
    for (int i = 2; i <= 10; i++) step(1'b1, 2'd0, {N{1'b0}});
    check_value("first_still_lit", 32'(mole_led[first_idx]), 32'd1);
    check_value("first_no_tmo_yet", 32'(timeout_pulse), 32'd0);
    step(1'b1, 2'd0, {N{1'b0}});
    check_value("first_expired", 32'(mole_led[first_idx]), 32'd0);
    check_value("first_timeout", 32'(timeout_pulse), 32'd1);
    step(1'b1, 2'd0, {N{1'b0}});
    check_value("timeout_one_cycle", 32'(timeout_pulse), 32'd0);

    // Single hit on a lit mole
    k = -1;
    for (int j = N - 1; j >= 0; j--) if (m_lit[j]) k = j;
    btn = {N{1'b0}};
    if (k >= 0) btn[k] = 1'b1;
    step(1'b1, 2'd0, btn);
    check_value("single_hit_found", 32'(k >= 0), 32'd1);
    if (k >= 0) check_value("single_hit_led", 32'(mole_led[k]), 32'd0);
    check_value("single_hit_pulse", 32'(hit_pulse), 32'd1);
    check_value("single_hit_count", 32'(hit_count), 32'd1);
    check_value("single_hit_no_tmo", 32'(timeout_pulse), 32'd0);

    // Two lit moles hit together plus a press on an unlit one
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (model_active() == 2) found = 1'b1;
      else step(1'b1, 2'd0, {N{1'b0}});
    end
    check_value("wait_two_lit", 32'(found), 32'd1);
    btn = exp_led;
    k = -1;
    for (int j = N - 1; j >= 0; j--) if (!m_lit[j]) k = j;
    if (k >= 0) btn[k] = 1'b1;
    step(1'b1, 2'd0, btn);
    check_value("double_hit_count", 32'(hit_count), 32'd2);
    check_value("double_hit_active", 32'(active_count), 32'd0);
    check_value("double_hit_miss", 32'(miss_pulse), 32'd1);

    // Press landing on the expiry cycle counts as a hit only
    found = 1'b0; k = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && m_lit[j] && m_life[j] == 1) begin
          found = 1'b1; k = j;
        end
      end
      if (!found) step(1'b1, 2'd0, {N{1'b0}});
    end
    check_value("wait_expiry", 32'(found), 32'd1);
    btn = {N{1'b0}};
    btn[k] = 1'b1;
    step(1'b1, 2'd0, btn);
    check_value("expiry_hit", 32'(hit_pulse), 32'd1);
    check_value("expiry_no_tmo", 32'(timeout_pulse), 32'd0);

    // Randomized play: levels, presses and occasional enable drops
    for (int i = 0; i < 1000; i++) begin
      rnd = $urandom;
      btn = ($urandom_range(0, 3) == 0) ? rnd[N-1:0] : {N{1'b0}};
      step(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)), btn);
    end

    // Freeze for 20 cycles with moles lit, then resume
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (model_active() > 0) found = 1'b1;
      else step(1'b1, 2'd1, {N{1'b0}});
    end
    check_value("wait_lit_for_freeze", 32'(found), 32'd1);
    snap = exp_led;
    for (int i = 0; i < 20; i++) begin
      rnd = $urandom;
      step(1'b0, 2'($urandom_range(0, 3)), rnd[N-1:0]);
      check_value("frozen_led", 32'(mole_led), 32'(snap));
      check_value("frozen_pulses", 32'({hit_pulse, miss_pulse, timeout_pulse}), 32'd0);
    end
    for (int i = 0; i < 15; i++) step(1'b1, 2'd2, {N{1'b0}});

    // Asynchronous reset mid-game, then spawn on the first enabled edge
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset(); clear_history();
    @(negedge clk_game);
    rst = 1'b0;
    step(1'b1, 2'd0, {N{1'b0}});
    check_value("post_rst_spawn", 32'(active_count), 32'd1);
    for (int i = 0; i < 12; i++) step(1'b1, 2'd0, {N{1'b0}});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
